queue: RTL and testbench

//  Synchronous FIFO queue: the first-in/first-out companion to the LIFO stack.

---
 rtl/queue.sv | 88 ++++++++
 tb/tb_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/queue.sv
// Synchronous FIFO of 2**DEPTH words with registered read data.
// Overflow/underflow are sticky and freeze the queue until reset.
module queue #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [DEPTH:0]   count,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int             ENTRIES  = 2**DEPTH;
  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(ENTRIES);
  localparam logic [DEPTH:0] CNT_ONE  = (DEPTH+1)'(1);
  localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [DEPTH-1:0] r_wr_ptr;
  logic [DEPTH-1:0] r_rd_ptr;
  logic [DEPTH:0]   r_count;
  logic [WIDTH-1:0] r_q;
  logic             r_ov;
  logic             r_un;

  logic w_empty;
  logic w_full;
  logic w_frozen;
  logic w_err_ov;
  logic w_err_un;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_frozen = r_ov | r_un;
  // A pop alongside a push on a full queue frees the slot, so it is not an overflow.
  assign w_err_ov = push & w_full & ~pop;
  assign w_err_un = pop & w_empty;
  assign w_do_push = push & ~w_frozen & ~w_err_ov & ~w_err_un;
  assign w_do_pop  = pop  & ~w_frozen & ~w_err_ov & ~w_err_un;

  // Storage is not reset; the read below sees pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_q      <= '0;
      r_ov     <= 1'b0;
      r_un     <= 1'b0;
    end else begin
      if (!w_frozen) begin
        if (w_err_ov) r_ov <= 1'b1;
        if (w_err_un) r_un <= 1'b1;
      end
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop) begin
        r_q      <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign q           = r_q;
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = r_count;
  assign overflow_o  = r_ov;
  assign underflow_o = r_un;

endmodule

// File: tb/tb_queue.sv
// Directed-vector bench for queue with 4 entries (WIDTH=11, DEPTH=2).
module tb_queue;

  localparam int WIDTH = 11;
  localparam int DEPTH = 2;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] d;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic [DEPTH:0]   count;
  logic             overflow_o;
  logic             underflow_o;

  int n_vec;
  int n_err;

  queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d          (d),
    .push       (push),
    .pop        (pop),
    .q          (q),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic ps, input logic pp, input logic [WIDTH-1:0] dv);
    push = ps;
    pop  = pp;
    d    = dv;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    d    = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".q"},     32'(q), 32'h0);
    chk({tag, ".count"}, 32'(count), 32'h0);
    chk({tag, ".empty"}, 32'(empty), 32'h1);
    chk({tag, ".full"},  32'(full), 32'h0);
    chk({tag, ".ov"},    32'(overflow_o), 32'h0);
    chk({tag, ".un"},    32'(underflow_o), 32'h0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    push    = 1'b0;
    pop     = 1'b0;
    d       = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_reset_state("init");

    // 1: reset mid-stream, then pop from the now-empty queue
    step(1'b1, 1'b0, 11'h055);
    step(1'b1, 1'b0, 11'h066);
    step(1'b0, 1'b1, 11'h000);
    chk("t1.q_before_rst", 32'(q), 32'h055);
    reset_n = 1'b0;
    #2;
    chk_reset_state("t1.rst");
    reset_n = 1'b1;
    step(1'b0, 1'b1, 11'h000);
    chk("t1.un", 32'(underflow_o), 32'h1);
    chk("t1.q", 32'(q), 32'h0);

    // 2: three pushes then three pops
    do_reset();
    step(1'b1, 1'b0, 11'h001);
    step(1'b1, 1'b0, 11'h002);
    step(1'b1, 1'b0, 11'h003);
    chk("t2.count3", 32'(count), 32'h3);
    step(1'b0, 1'b1, 11'h000);
    chk("t2.q1", 32'(q), 32'h001);
    chk("t2.count2", 32'(count), 32'h2);
    step(1'b0, 1'b1, 11'h000);
    chk("t2.q2", 32'(q), 32'h002);
    step(1'b0, 1'b1, 11'h000);
    chk("t2.q3", 32'(q), 32'h003);
    chk("t2.count0", 32'(count), 32'h0);
    chk("t2.empty", 32'(empty), 32'h1);
    chk("t2.un", 32'(underflow_o), 32'h0);

    // 3: fill, overflow, then frozen
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 11'(32'h010 + i));
    chk("t3.full", 32'(full), 32'h1);
    chk("t3.count4", 32'(count), 32'h4);
    step(1'b1, 1'b0, 11'h014);
    chk("t3.ov", 32'(overflow_o), 32'h1);
    chk("t3.count_ov", 32'(count), 32'h4);
    step(1'b0, 1'b1, 11'h000);
    step(1'b0, 1'b1, 11'h000);
    chk("t3.q_frozen", 32'(q), 32'h0);
    chk("t3.count_frozen", 32'(count), 32'h4);
    chk("t3.un", 32'(underflow_o), 32'h0);

    // 4: push+pop on a full queue reads the old head
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 11'(32'h0A1 + i));
    step(1'b1, 1'b1, 11'h0A5);
    chk("t4.qA", 32'(q), 32'h0A1);
    chk("t4.count", 32'(count), 32'h4);
    chk("t4.ov", 32'(overflow_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 11'h000);
      chk($sformatf("t4.pop%0d", i), 32'(q), 32'h0A2 + i);
    end
    chk("t4.empty", 32'(empty), 32'h1);
    chk("t4.un", 32'(underflow_o), 32'h0);

    // 5: push+pop on empty is an underflow and drops the write
    do_reset();
    step(1'b1, 1'b1, 11'h3FF);
    chk("t5.un", 32'(underflow_o), 32'h1);
    chk("t5.count", 32'(count), 32'h0);
    chk("t5.empty", 32'(empty), 32'h1);
    chk("t5.q", 32'(q), 32'h0);

    // 6: alternating push/pop wraps both pointers
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 11'(32'h100 + i));
      chk($sformatf("t6.count_push%0d", i), 32'(count), 32'h1);
      step(1'b0, 1'b1, 11'h000);
      chk($sformatf("t6.q%0d", i), 32'(q), 32'h100 + i);
      chk($sformatf("t6.count_pop%0d", i), 32'(count), 32'h0);
    end
    chk("t6.ov", 32'(overflow_o), 32'h0);
    chk("t6.un", 32'(underflow_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
